// File: rtl/ps2_host_cmd_ctrl_if.sv
// Signal bundle between the PS/2 host command sequencer, its requester and the pads.
// Every signal here is a plain level; there are no byte-wide handshake buses other than cmd_data.
interface ps2_host_cmd_ctrl_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       rx_hold;
    logic       done;
    logic       ack_ok;
    logic       timeout;
    logic [2:0] state_dbg;

    // cmd_valid/cmd_ready: a command transfers on a rising clk edge where both are high;
    // the requester holds cmd_valid and cmd_data stable until that edge.
    modport master (
        output cmd_valid, cmd_data, ps2_clk_in, ps2_dat_in,
        input  cmd_ready, ps2_clk_oe, ps2_dat_oe, rx_hold, done, ack_ok, timeout, state_dbg
    );

    modport slave (
        input  cmd_valid, cmd_data, ps2_clk_in, ps2_dat_in,
        output cmd_ready, ps2_clk_oe, ps2_dat_oe, rx_hold, done, ack_ok, timeout, state_dbg
    );
endinterface

// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host-to-device command sender: inhibits the clock, requests to send, shifts one
// odd-parity byte out on device clock falls, then reports ACK, NACK or timeout.
module ps2_host_cmd_ctrl #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 250,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic               clk,
    input  logic               rst,
    ps2_host_cmd_ctrl_if.slave bus
);

    localparam int PW = $clog2(INHIBIT_CYCLES + RTS_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] INH_LAST = PW'(INHIBIT_CYCLES - 1);
    localparam logic [PW-1:0] RTS_LAST = PW'(RTS_CYCLES - 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INHIBIT  = 3'd1;
    localparam logic [2:0] S_RTS      = 3'd2;
    localparam logic [2:0] S_SEND     = 3'd3;
    localparam logic [2:0] S_WAIT_ACK = 3'd4;
    localparam logic [2:0] S_WAIT_REL = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [7:0]    clk_sr_q, dat_sr_q;
    logic          clk_f_q, dat_f_q, clk_f_prev_q;
    logic [3:0]    warm_q;
    logic          fall, primed, ready, timed;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] to_q, to_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          ack_q, ack_d;
    logic          tof_q, tof_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;

    // warm_q keeps cmd_ready low until the filters hold real pad samples after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sr_q     <= 8'hFF;
            dat_sr_q     <= 8'hFF;
            clk_f_q      <= 1'b1;
            dat_f_q      <= 1'b1;
            clk_f_prev_q <= 1'b1;
            warm_q       <= 4'd0;
        end else begin
            clk_sr_q     <= {clk_sr_q[6:0], bus.ps2_clk_in};
            dat_sr_q     <= {dat_sr_q[6:0], bus.ps2_dat_in};
            if (&clk_sr_q)       clk_f_q <= 1'b1;
            else if (~|clk_sr_q) clk_f_q <= 1'b0;
            if (&dat_sr_q)       dat_f_q <= 1'b1;
            else if (~|dat_sr_q) dat_f_q <= 1'b0;
            clk_f_prev_q <= clk_f_q;
            if (warm_q != 4'd9) warm_q <= warm_q + 4'd1;
        end
    end

    assign fall   = clk_f_prev_q & ~clk_f_q;
    assign primed = (warm_q == 4'd9);
    assign ready  = (state_q == S_IDLE) & primed & clk_f_q & dat_f_q;
    assign timed  = (state_q == S_RTS) | (state_q == S_SEND) |
                    (state_q == S_WAIT_ACK) | (state_q == S_WAIT_REL);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        to_d     = (timed && to_q != TO_LIMIT) ? to_q + 1'b1 : to_q;
        bit_d    = bit_q;
        data_d   = data_q;
        par_d    = par_q;
        ack_d    = ack_q;
        tof_d    = tof_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        case (state_q)
            S_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (bus.cmd_valid && ready) begin
                    data_d   = bus.cmd_data;
                    par_d    = ~^bus.cmd_data;
                    ack_d    = 1'b0;
                    tof_d    = 1'b0;
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d    = '0;
                    to_d     = '0;
                    dat_oe_d = 1'b1;
                    state_d  = S_RTS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RTS: begin
                if (cnt_q == RTS_LAST) begin
                    clk_oe_d = 1'b0;
                    bit_d    = 4'd0;
                    state_d  = S_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                // the start bit stays on the line until the device's first falling edge
                if (fall) begin
                    if (bit_q < 4'd8)       dat_oe_d = ~data_q[bit_q[2:0]];
                    else if (bit_q == 4'd8) dat_oe_d = ~par_q;
                    else                    dat_oe_d = 1'b0;
                    if (bit_q == 4'd9) state_d = S_WAIT_ACK;
                    else               bit_d   = bit_q + 4'd1;
                end
            end
            S_WAIT_ACK: begin
                if (fall) begin
                    ack_d   = ~dat_f_q;
                    state_d = S_WAIT_REL;
                end
            end
            S_WAIT_REL: begin
                if (clk_f_q && dat_f_q) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
        // timeout overrides whatever the bus phase wanted this cycle
        if (timed && to_q == TO_LIMIT) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            ack_d    = 1'b0;
            tof_d    = 1'b1;
            state_d  = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            to_q     <= '0;
            bit_q    <= 4'd0;
            data_q   <= 8'h00;
            par_q    <= 1'b0;
            ack_q    <= 1'b0;
            tof_q    <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            par_q    <= par_d;
            ack_q    <= ack_d;
            tof_q    <= tof_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
        end
    end

    assign bus.cmd_ready  = ready;
    assign bus.ps2_clk_oe = clk_oe_q;
    assign bus.ps2_dat_oe = dat_oe_q;
    assign bus.rx_hold    = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.ack_ok     = (state_q == S_DONE) & ack_q;
    assign bus.timeout    = (state_q == S_DONE) & tof_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Bench for ps2_host_cmd_ctrl: an open-drain pad model plus a keyboard model that clocks
// frames in, checked against a frame-level reference model and a table of known commands.
module tb_ps2_host_cmd_ctrl;

    localparam int INH = 40;
    localparam int RTS = 12;
    localparam int TO  = 2000;

    typedef struct {
        logic [7:0] cmd;
        int         mode;     // 0 = device ACKs, 1 = device NACKs, 2 = device never clocks
        logic       exp_par;
        logic       exp_ack;
        logic       exp_to;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [10:0] exp_q[$];
    vec_t vecs[5];

    ps2_host_cmd_ctrl_if bus();

    // open-drain pads: either side pulling low wins
    assign bus.ps2_clk_in = ~(bus.ps2_clk_oe | dev_clk_low);
    assign bus.ps2_dat_in = ~(bus.ps2_dat_oe | dev_dat_low);

    ps2_host_cmd_ctrl #(
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES    (RTS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // frame as the device sees it on rising edges: start, data LSB first, odd parity, stop
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        f = '0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic dev_pulse(output logic s);
        dev_clk_low = 1'b1;
        repeat (25) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        s = bus.ps2_dat_in;
        repeat (22) @(negedge clk);
    endtask

    // request a command and follow it through the inhibit and request-to-send phases
    task automatic start_cmd(input logic [7:0] cmd, input bit held, output bit ok, output int rts_cyc);
        int n, t_rts;
        ok = 1'b0;
        rts_cyc = 0;
        if (!held) @(negedge clk);
        bus.cmd_data  = cmd;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            check("cmd_accept_bound", bus.cmd_ready, 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("clk_oe_after_accept", bus.ps2_clk_oe, 1);
        check("rx_hold_after_accept", bus.rx_hold, 1);
        n = 1;
        t_rts = -1;
        while (bus.ps2_clk_oe === 1'b1 && n < INH + RTS + 50) begin
            if (bus.ps2_dat_oe === 1'b1 && t_rts < 0) begin
                t_rts = n;
                rts_cyc = cyc;
            end
            @(negedge clk);
            n++;
        end
        check("clk_low_cycles", n - 1, INH + RTS);
        check("rts_entry_cycle", t_rts, INH + 1);
        check("start_bit_held", bus.ps2_dat_oe, 1);
        ok = (n - 1 == INH + RTS);
    endtask

    task automatic wait_done(input int limit, output logic seen, output logic ack, output logic to);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        seen = (bus.done === 1'b1);
        check("done_within_bound", seen, 1);
        ack = bus.ack_ok;
        to  = bus.timeout;
        if (seen) begin
            check("oe_released_at_done", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
            check("ready_low_at_done", bus.cmd_ready, 0);
            check("rx_hold_at_done", bus.rx_hold, 1);
            @(negedge clk);
            check("done_one_cycle", bus.done, 0);
            check("rx_hold_after_done", bus.rx_hold, 0);
        end
    endtask

    task automatic xfer(input logic [7:0] cmd, input int mode, input bit held,
                        output logic [10:0] frame, output logic ack, output logic to);
        bit   ok;
        int   rts_cyc;
        logic s, seen;
        frame = '0;
        ack = 1'b0;
        to  = 1'b0;
        start_cmd(cmd, held, ok, rts_cyc);
        if (!ok) return;
        if (mode == 2) begin
            wait_done(TO + 200, seen, ack, to);
            if (seen) check_range("timeout_latency", cyc - rts_cyc, TO, TO + 2);
            return;
        end
        repeat (15) @(negedge clk);
        frame[0] = bus.ps2_dat_in;
        for (int i = 0; i < 10; i++) begin
            dev_pulse(s);
            frame[i+1] = s;
        end
        if (mode == 0) dev_dat_low = 1'b1;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (25) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_dat_low = 1'b0;
        wait_done(200, seen, ack, to);
    endtask

    task automatic run_case(input vec_t v, input bit held, input bit chk_par);
        logic [10:0] frame, exp;
        logic ack, to;
        if (v.mode != 2) exp_q.push_back(model_frame(v.cmd));
        xfer(v.cmd, v.mode, held, frame, ack, to);
        if (v.mode != 2 && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("frame_bits", frame, exp);
            if (chk_par) check("parity_bit", frame[9], v.exp_par);
        end
        check("ack_ok", ack, v.exp_ack);
        check("timeout", to, v.exp_to);
    endtask

    initial begin
        int   n, bad;
        bit   ok;
        int   rts_cyc;
        logic s;
        vec_t rv;

        vecs[0] = '{cmd: 8'hF4, mode: 0, exp_par: 1'b0, exp_ack: 1'b1, exp_to: 1'b0};
        vecs[1] = '{cmd: 8'hED, mode: 0, exp_par: 1'b1, exp_ack: 1'b1, exp_to: 1'b0};
        vecs[2] = '{cmd: 8'h00, mode: 1, exp_par: 1'b1, exp_ack: 1'b0, exp_to: 1'b0};
        vecs[3] = '{cmd: 8'h5A, mode: 2, exp_par: 1'b1, exp_ack: 1'b0, exp_to: 1'b1};
        vecs[4] = '{cmd: 8'h80, mode: 0, exp_par: 1'b0, exp_ack: 1'b1, exp_to: 1'b0};

        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bus.cmd_ready, bus.ps2_clk_oe, bus.ps2_dat_oe, bus.rx_hold, bus.done, bus.ack_ok, bus.timeout}, 0);
        rst = 1'b1;
        #1;
        check("ready_low_after_reset", bus.cmd_ready, 0);
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_range("ready_rise_after_reset", n, 8, 11);

        for (int i = 0; i < 5; i++) run_case(vecs[i], 1'b0, 1'b1);

        // device holding the clock low: request must wait for the filtered idle bus
        @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (12) @(negedge clk);
        bus.cmd_data  = 8'hFF;
        bus.cmd_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_ready !== 1'b0 || bus.rx_hold !== 1'b0) bad++;
            @(negedge clk);
        end
        check("busy_bus_not_accepted", bad, 0);
        dev_clk_low = 1'b0;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_range("ready_after_bus_idle", n, 9, 10);
        rv = '{cmd: 8'hFF, mode: 0, exp_par: 1'b1, exp_ack: 1'b1, exp_to: 1'b0};
        run_case(rv, 1'b1, 1'b1);

        // reset while bit 4 of 0x00 is on the line
        start_cmd(8'h00, 1'b0, ok, rts_cyc);
        if (ok) begin
            repeat (15) @(negedge clk);
            for (int i = 0; i < 4; i++) dev_pulse(s);
            dev_clk_low = 1'b1;
            repeat (25) @(negedge clk);
            check("dat_oe_bit4_before_reset", bus.ps2_dat_oe, 1);
            #2;
            rst = 1'b0;
            #1;
            check("async_reset_release", {bus.ps2_clk_oe, bus.ps2_dat_oe, bus.rx_hold, bus.done}, 0);
            bad = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bus.done !== 1'b0) bad++;
            end
            dev_clk_low = 1'b0;
            rst = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.done !== 1'b0) bad++;
            end
            check("no_done_after_reset", bad, 0);
        end
        run_case(vecs[0], 1'b0, 1'b1);

        // randomized commands against the frame model
        for (int i = 0; i < 6; i++) begin
            rv.cmd     = 8'($urandom_range(0, 255));
            rv.mode    = int'($urandom_range(0, 1));
            rv.exp_par = 1'b0;
            rv.exp_ack = (rv.mode == 0);
            rv.exp_to  = 1'b0;
            run_case(rv, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
